redmule_x_pad_ctrl: RTL and testbench
=====================================

# redmule_x_pad_ctrl

Sequencer for the X-pad standard-cell-memory buffer. It fills the buffer row by row from a handshaked input stream and zero-pads any rows beyond the programmed tile height. It then drains the buffer column by column to a handshaked consumer. The block sits between the X streamer and the X buffer's SCM, and drives only the SCM's control and address pins plus a zero-mask for its write data.

## Interface
- `ROWS`, default 8: SCM rows (write-word count); must be ≥2.
- `COLS`, default 8: SCM columns (read-word count); must be ≥2.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `clear_i`  in  1  synchronous abort and buffer clear.
- `start_i`  in  1  start a tile; accepted only in IDLE.
- `rows_i`  in  $clog2(ROWS+1)  valid rows in the tile; values >ROWS are clamped to ROWS.
- `cols_i`  in  $clog2(COLS+1)  valid columns to drain; values >COLS are clamped to COLS.
- `in_valid_i` / `in_ready_o`  in/out  1  input row handshake.
- `out_valid_o` / `out_ready_i`  out/in  1  output column handshake.
- `out_last_o`  out  1  marks the final column of the tile.
- `scm_write_en_o`  out  1  SCM write enable.
- `scm_write_addr_o`  out  $clog2(ROWS)  SCM write row.
- `scm_wdata_zero_o`  out  1  datapath forces the SCM wdata to 0 for this write.
- `scm_read_en_o`  out  1  SCM read-address sample enable.
- `scm_read_addr_o`  out  $clog2(COLS)  SCM read column.
- `scm_clear_o`  out  1  SCM clear.
- `busy_o`  out  1  state ≠ IDLE.
- `done_o`  out  1  one-cycle pulse when the tile completes.

## Operation
- States: IDLE, FILL, SETTLE, DRAIN.
- **IDLE**
  - On `start_i`: latch the clamped `rows_i`/`cols_i`, clear the row counter r and the column counters, then go to FILL.
  - If either the clamped rows or cols value is 0: no SCM access, pulse `done_o` next cycle, stay in IDLE.
- **FILL** (r runs 0..ROWS-1):
  - r < rows: `in_ready_o`=1, and `scm_write_en_o` = `in_valid_i`. r increments on handshake.
  - r ≥ rows: `in_ready_o`=0, `scm_write_en_o`=1, `scm_wdata_zero_o`=1. r increments every cycle.
  - `scm_write_addr_o` = r.
  - When the write at r=ROWS-1 occurs, go to SETTLE.
- **SETTLE**: one bubble cycle with no SCM access, so the last write lands before the first read. Then go to DRAIN.
- **DRAIN**
  - Issue counter c runs 0..cols-1.
  - `scm_read_en_o` = (c < cols) && (!`out_valid_o` || `out_ready_i`), with `scm_read_addr_o` = c.
  - `out_valid_o` is registered: set the cycle after a read issue; cleared on handshake when no new read is issued.
  - `out_last_o` = `out_valid_o` && (the current output's column == cols-1).
  - On the handshake of the last column: pulse `done_o` and go to IDLE.
- **clear_i** (any state): `scm_clear_o`=1 that cycle, state→IDLE, all counters and `out_valid_o` → 0. There is no `done_o` pulse. Priority: `clear_i` > `start_i`.
- `start_i` while busy is ignored.
- Counters are `$clog2(ROWS+1)` / `$clog2(COLS+1)` bits wide; they never wrap because the terminal checks precede any overflow.

## Timing
- Reset: state IDLE, counters 0, every output 0 (`in_ready_o` = 0, `out_valid_o` = 0, `done_o` = 0).
- `start_i` at cycle T → FILL at T+1, with the first `in_ready_o` at T+1.
- Full-rate tile (all valid/ready high), ROWS=COLS=8:
  - writes at T+1..T+8, SETTLE at T+9, reads at T+10..T+17;
  - `out_valid_o` high from T+11 through T+18;
  - `done_o` at T+18, IDLE at T+19.
- Read data is valid the cycle after `scm_read_en_o` and stays stable while `out_valid_o` && !`out_ready_i` (no read issued then).
- Throughput in DRAIN is 1 column/cycle with `out_ready_i`=1.
- `rst_i` mid-operation returns everything to reset values immediately; the SCM contents are undefined afterwards.

## Structure
- Add the `x_pad_ctrl_state_e` enum (IDLE, FILL, SETTLE, DRAIN) to `redmule_pkg`.
- No new constants are needed; ROWS/COLS come from the existing X-buffer geometry parameters.
- Single module, no sub-modules. Counters and the FSM are inline.

## Test plan
- Full tile, ROWS=COLS=8, rows=8, cols=8, valid/ready held high → 8 writes with addr 0..7 and zero-mask 0; first read 2 cycles after the last write; 8 outputs; `out_last_o` on the 8th; `done_o` 18 cycles after start.
- rows=5 → rows 5..7 written on consecutive cycles with `scm_wdata_zero_o`=1 and `in_ready_o`=0; `in_valid_i` toggling during rows 0..4 stalls r correctly.
- cols=3 with `out_ready_i` low for 4 cycles on column 1 → `scm_read_en_o` held low and output stable; 3 outputs in total; `out_last_o` on column 2.
- `clear_i` during FILL at r=3 → `scm_clear_o` for 1 cycle, IDLE next cycle, no `done_o`; a following start runs a clean tile.
- `start_i` pulsed in FILL/DRAIN → ignored; rows=0 or cols=0 → `done_o` next cycle with no SCM activity; rows_i=15 → clamped to 8.
- `rst_i` asserted mid-DRAIN → all outputs 0 and `busy_o`=0 asynchronously; normal operation after release.

Source files
------------

// File: rtl/redmule_pkg.sv
// Shared RedMulE types.
// Holds the X-pad sequencer state encoding.
package redmule_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SETTLE,
        DRAIN
    } x_pad_ctrl_state_e;

endpackage

// File: rtl/redmule_x_pad_ctrl.sv
// X-pad SCM sequencer: fills rows from the streamer, zero-pads the
// rows past the tile height, then drains columns to the consumer.
module redmule_x_pad_ctrl
    import redmule_pkg::*;
#(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8,
    localparam int unsigned RW  = $clog2(ROWS + 1),
    localparam int unsigned CW  = $clog2(COLS + 1),
    localparam int unsigned RAW = $clog2(ROWS),
    localparam int unsigned CAW = $clog2(COLS)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clear_i,
    input  logic           start_i,
    input  logic [RW-1:0]  rows_i,
    input  logic [CW-1:0]  cols_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic           out_last_o,
    output logic           scm_write_en_o,
    output logic [RAW-1:0] scm_write_addr_o,
    output logic           scm_wdata_zero_o,
    output logic           scm_read_en_o,
    output logic [CAW-1:0] scm_read_addr_o,
    output logic           scm_clear_o,
    output logic           busy_o,
    output logic           done_o
);

    x_pad_ctrl_state_e state_q, state_d;
    logic [RW-1:0] rows_q, rows_d, r_q, r_d, rows_cl;
    logic [CW-1:0] cols_q, cols_d, c_q, c_d, oc_q, oc_d, cols_cl;
    logic          valid_q, valid_d, done_q, done_d;
    logic          last, hs, done_now;

    assign rows_cl = (rows_i > RW'(ROWS)) ? RW'(ROWS) : rows_i;
    assign cols_cl = (cols_i > CW'(COLS)) ? CW'(COLS) : cols_i;

    // oc_q tracks the column currently held on the output
    assign last = valid_q && (oc_q == cols_q - CW'(1));
    assign hs   = valid_q && out_ready_i;

    always_comb begin
        state_d          = state_q;
        rows_d           = rows_q;
        cols_d           = cols_q;
        r_d              = r_q;
        c_d              = c_q;
        oc_d             = oc_q;
        valid_d          = valid_q;
        done_d           = 1'b0;
        done_now         = 1'b0;
        in_ready_o       = 1'b0;
        scm_write_en_o   = 1'b0;
        scm_write_addr_o = '0;
        scm_wdata_zero_o = 1'b0;
        scm_read_en_o    = 1'b0;
        scm_read_addr_o  = '0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    rows_d  = rows_cl;
                    cols_d  = cols_cl;
                    r_d     = '0;
                    c_d     = '0;
                    oc_d    = '0;
                    valid_d = 1'b0;
                    if (rows_cl == '0 || cols_cl == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                scm_write_addr_o = r_q[RAW-1:0];
                if (r_q < rows_q) begin
                    in_ready_o     = 1'b1;
                    scm_write_en_o = in_valid_i;
                end else begin
                    scm_write_en_o   = 1'b1;
                    scm_wdata_zero_o = 1'b1;
                end
                if (scm_write_en_o) begin
                    r_d = r_q + RW'(1);
                    if (r_q == RW'(ROWS - 1)) begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                scm_read_en_o   = (c_q < cols_q) && (!valid_q || out_ready_i);
                scm_read_addr_o = c_q[CAW-1:0];
                if (scm_read_en_o) begin
                    c_d     = c_q + CW'(1);
                    valid_d = 1'b1;
                end else if (hs) begin
                    valid_d = 1'b0;
                end
                if (hs) begin
                    oc_d = oc_q + CW'(1);
                    if (last) begin
                        done_now = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d        = IDLE;
            r_d            = '0;
            c_d            = '0;
            oc_d           = '0;
            valid_d        = 1'b0;
            done_d         = 1'b0;
            done_now       = 1'b0;
            in_ready_o     = 1'b0;
            scm_write_en_o = 1'b0;
            scm_read_en_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rows_q  <= '0;
            cols_q  <= '0;
            r_q     <= '0;
            c_q     <= '0;
            oc_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            r_q     <= r_d;
            c_q     <= c_d;
            oc_q    <= oc_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_last_o  = last;
    assign scm_clear_o = clear_i;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q | done_now;

endmodule

// File: tb/tb_redmule_x_pad_ctrl.sv
// Scoreboard bench for redmule_x_pad_ctrl (ROWS=COLS=8).
// Stimulus pushes expected writes/outputs; a negedge monitor checks them.
module tb_redmule_x_pad_ctrl;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    typedef struct {
        int addr;
        bit zero;
    } wr_t;

    typedef struct {
        int col;
        bit last;
    } out_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_i, start_i;
    logic [3:0] rows_i, cols_i;
    logic       in_valid_i, in_ready_o;
    logic       out_valid_o, out_ready_i, out_last_o;
    logic       scm_write_en_o, scm_wdata_zero_o;
    logic [2:0] scm_write_addr_o, scm_read_addr_o;
    logic       scm_read_en_o, scm_clear_o, busy_o, done_o;

    redmule_x_pad_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .clear_i         (clear_i),
        .start_i         (start_i),
        .rows_i          (rows_i),
        .cols_i          (cols_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_last_o      (out_last_o),
        .scm_write_en_o  (scm_write_en_o),
        .scm_write_addr_o(scm_write_addr_o),
        .scm_wdata_zero_o(scm_wdata_zero_o),
        .scm_read_en_o   (scm_read_en_o),
        .scm_read_addr_o (scm_read_addr_o),
        .scm_clear_o     (scm_clear_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;
    int   last_wr_cyc = 0;
    int   first_rd_cyc = 0;
    bit   first_arm = 0;
    int   rd_data = 0;
    wr_t  wq[$];
    out_t oq[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event seen, none expected", nm);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SCM read model: data word equals the column it was read from
    always @(posedge clk) if (scm_read_en_o) rd_data <= int'(scm_read_addr_o);

    always @(negedge clk) begin
        if (!rst) begin
            if (scm_write_en_o) begin
                last_wr_cyc = cyc;
                if (wq.size() == 0) bad("unexpected_write");
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", int'(scm_write_addr_o), w.addr);
                    chk("wr_zero", int'(scm_wdata_zero_o), int'(w.zero));
                    chk("wr_in_ready", int'(in_ready_o), int'(!w.zero));
                end
            end
            if (out_valid_o && !out_ready_i)
                chk("stall_no_read", int'(scm_read_en_o), 0);
            if (out_valid_o && out_ready_i) begin
                if (oq.size() == 0) bad("unexpected_output");
                else begin
                    out_t o;
                    o = oq.pop_front();
                    chk("out_col", rd_data, o.col);
                    chk("out_last", int'(out_last_o), int'(o.last));
                end
            end
            if (scm_read_en_o) begin
                if (oq.size() == 0) bad("unexpected_read");
                if (first_arm) begin
                    first_rd_cyc = cyc;
                    first_arm = 0;
                end
            end
            if (done_o) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_tile(input int rr, input int cc, input bit tog,
                            input int st_at, input int st_len, input bit spam,
                            output int t0, output int td);
        int re, ce, d0;
        bit seen;
        re = (rr > ROWS) ? ROWS : rr;
        ce = (cc > COLS) ? COLS : cc;
        if (re > 0 && ce > 0) begin
            for (int i = 0; i < ROWS; i++) wq.push_back('{addr: i, zero: (i >= re)});
            for (int j = 0; j < ce; j++) oq.push_back('{col: j, last: (j == ce - 1)});
        end
        first_arm   = 1;
        rows_i      = 4'(rr);
        cols_i      = 4'(cc);
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        start_i     = 1'b1;
        t0   = cyc;
        d0   = done_cnt;
        seen = 0;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            if (tog) in_valid_i = ~in_valid_i;
            out_ready_i = !(st_len > 0 && cyc >= t0 + st_at && cyc < t0 + st_at + st_len);
            start_i = spam && (cyc == t0 + 3 || cyc == t0 + 12);
            @(negedge clk);
            if (done_cnt != d0) seen = 1;
            tick();
        end
        start_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        td = last_done_cyc;
        chk("tile_done_seen", int'(seen), 1);
        chk("queues_empty", wq.size() + oq.size(), 0);
        chk("idle_after_tile", int'(busy_o), 0);
    endtask

    initial begin
        int t0, td, d0;
        rst = 1'b1;
        clear_i = 1'b0;
        start_i = 1'b0;
        rows_i = '0;
        cols_i = '0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        repeat (3) tick();
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_in_ready", int'(in_ready_o), 0);
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_wr_en", int'(scm_write_en_o), 0);
        chk("rst_rd_en", int'(scm_read_en_o), 0);
        rst = 1'b0;
        tick();

        run_tile(8, 8, 0, 0, 0, 0, t0, td);
        chk("full_done_latency", td - t0, 18);
        chk("first_read_gap", first_rd_cyc - last_wr_cyc, 2);

        run_tile(5, 8, 1, 0, 0, 0, t0, td);

        run_tile(8, 3, 0, 12, 4, 0, t0, td);
        chk("stall_done_latency", td - t0, 17);

        run_tile(8, 8, 0, 0, 0, 1, t0, td);
        chk("spam_done_latency", td - t0, 18);

        run_tile(0, 5, 0, 0, 0, 0, t0, td);
        chk("rows0_done_latency", td - t0, 1);
        run_tile(3, 0, 0, 0, 0, 0, t0, td);
        chk("cols0_done_latency", td - t0, 1);

        run_tile(15, 15, 0, 0, 0, 0, t0, td);
        chk("clamp_done_latency", td - t0, 18);

        // abort during fill at row 3
        for (int i = 0; i < 3; i++) wq.push_back('{addr: i, zero: 1'b0});
        rows_i = 4'd8;
        cols_i = 4'd8;
        in_valid_i = 1'b1;
        start_i = 1'b1;
        d0 = done_cnt;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        clear_i = 1'b1;
        @(negedge clk);
        chk("clear_pulse", int'(scm_clear_o), 1);
        chk("clear_no_write", int'(scm_write_en_o), 0);
        tick();
        clear_i = 1'b0;
        in_valid_i = 1'b0;
        chk("clear_idle", int'(busy_o), 0);
        chk("clear_one_cycle", int'(scm_clear_o), 0);
        repeat (5) tick();
        chk("clear_no_done", done_cnt - d0, 0);
        chk("clear_writes", wq.size(), 0);
        run_tile(8, 8, 0, 0, 0, 0, t0, td);
        chk("post_clear_latency", td - t0, 18);

        // reset in the middle of drain
        for (int i = 0; i < ROWS; i++) wq.push_back('{addr: i, zero: 1'b0});
        for (int j = 0; j < COLS; j++) oq.push_back('{col: j, last: (j == COLS - 1)});
        rows_i = 4'd8;
        cols_i = 4'd8;
        in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (12) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy_o), 0);
        chk("mid_rst_out_valid", int'(out_valid_o), 0);
        chk("mid_rst_rd_en", int'(scm_read_en_o), 0);
        chk("mid_rst_wr_en", int'(scm_write_en_o), 0);
        chk("mid_rst_done", int'(done_o), 0);
        chk("mid_rst_popped", oq.size(), COLS - 2);
        oq.delete();
        tick();
        rst = 1'b0;
        in_valid_i = 1'b0;
        tick();
        run_tile(8, 8, 0, 0, 0, 0, t0, td);
        chk("post_rst_latency", td - t0, 18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
